// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- instruction fetch / program-counter stage.
//
// Holds the fetch PC and fetches one word at a time from instruction memory
// over a req/ack handshake. Each fetched word is presented to decode as a
// registered instruction. Redirects from execute (relative or absolute)
// retarget the fetch PC. A request that is still waiting for its ack when a
// redirect arrives is drained: it stays up at its old address, and the word
// it returns is thrown away.
//
// Ports:
//   clock                   rising-edge clock
//   reset                   asynchronous, active-low reset
//   pcchange[8:0]           signed relative redirect offset
//   pcjumpenable[2:0]       redirect code (1,4 relative; 2,3 absolute)
//   pclocation[5:0]         absolute redirect target, zero-extended
//   stall                   downstream cannot take a new instruction
//   imem_req                fetch request, held until imem_ack
//   imem_addr               fetch address, stable while imem_req is high
//   imem_ack                memory returns imem_data this cycle
//   imem_data               fetched word
//   instruction             registered instruction to decode
//   instruction_valid       instruction is live
//   programcounter          next fetch address
//   previous_programcounter address of the presented instruction
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int                  PC_WIDTH     = 20,
    parameter int                  INSTR_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [8:0]             pcchange,
    input  logic [2:0]             pcjumpenable,
    input  logic [5:0]             pclocation,
    input  logic                   stall,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instruction_valid,
    output logic [PC_WIDTH-1:0]    programcounter,
    output logic [PC_WIDTH-1:0]    previous_programcounter
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

    state_t state, state_nxt;

    logic [PC_WIDTH-1:0]    fetch_pc_p0;
    logic [PC_WIDTH-1:0]    drain_addr_p0;
    logic [INSTR_WIDTH-1:0] instr_p1;
    logic                   vld_p1;
    logic [PC_WIDTH-1:0]    pc_p1;

    logic                   redirect_hit;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   ack_take;

    // Relative redirects are based on the address of the presented
    // instruction, not on the fetch PC, and wrap modulo 2^PC_WIDTH.
    function automatic logic [PC_WIDTH-1:0] redirect_target(
        input logic [2:0]          code,
        input logic [PC_WIDTH-1:0] base,
        input logic signed [8:0]   rel,
        input logic [5:0]          abs_loc
    );
        logic signed [PC_WIDTH-1:0] rel_ext;
        rel_ext = {{(PC_WIDTH-9){rel[8]}}, rel};
        case (code)
            3'd1, 3'd4: redirect_target = base + $unsigned(rel_ext);
            3'd2, 3'd3: redirect_target = {{(PC_WIDTH-6){1'b0}}, abs_loc};
            default:    redirect_target = base;
        endcase
    endfunction

    // Codes 5-7 are treated as "no redirect".
    assign redirect_hit = (pcjumpenable != 3'd0) && (pcjumpenable <= 3'd4);
    assign redirect_pc  = redirect_target(pcjumpenable, pc_p1, pcchange, pclocation);
    assign ack_take     = imem_req && imem_ack;

    // ---- state register ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_nxt = state;
        if (redirect_hit) begin
            // An un-acked request cannot be withdrawn, so it is drained.
            state_nxt = (imem_req && !imem_ack) ? DRAIN : REQ;
        end else begin
            case (state)
                IDLE:    state_nxt = REQ;
                REQ: begin
                    if (ack_take)
                        state_nxt = stall ? HOLD : REQ;
                    else if (!imem_req)
                        state_nxt = HOLD;
                end
                HOLD:    state_nxt = stall ? HOLD : REQ;
                DRAIN:   state_nxt = imem_ack ? REQ : DRAIN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ---- output logic ----
    // A new request is not started while a live instruction is stalled.
    // Once a request is up without an ack, the presented instruction is
    // either consumed or already invalid, so the request stays up.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = fetch_pc_p0;
        case (state)
            REQ:     imem_req = !(vld_p1 && stall);
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr_p0;
            end
            default: imem_req = 1'b0;
        endcase
    end

    // ---- fetch (p0) -> decode-facing (p1) registers ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_p0   <= RESET_VECTOR;
            drain_addr_p0 <= RESET_VECTOR;
            instr_p1      <= '0;
            vld_p1        <= 1'b0;
            pc_p1         <= '0;
        end else if (redirect_hit) begin
            fetch_pc_p0 <= redirect_pc;
            vld_p1      <= 1'b0;
            if (imem_req && !imem_ack)
                drain_addr_p0 <= imem_addr;
        end else begin
            case (state)
                REQ: begin
                    if (ack_take) begin
                        instr_p1    <= imem_data;
                        vld_p1      <= 1'b1;
                        pc_p1       <= fetch_pc_p0;
                        fetch_pc_p0 <= fetch_pc_p0 + {{(PC_WIDTH-1){1'b0}}, 1'b1};
                    end else if (!stall) begin
                        // Presented instruction was consumed; nothing new yet.
                        vld_p1 <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall)
                        vld_p1 <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign instruction             = instr_p1;
    assign instruction_valid       = vld_p1;
    assign programcounter          = fetch_pc_p0;
    assign previous_programcounter = pc_p1;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int PCW = 20;
    localparam int IW  = 32;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [8:0]     pcchange = '0;
    logic [2:0]     pcjumpenable = '0;
    logic [5:0]     pclocation = '0;
    logic           stall = 1'b0;
    logic           imem_ack = 1'b0;

    logic           imem_req,    w_imem_req;
    logic [PCW-1:0] imem_addr,   w_imem_addr;
    logic [IW-1:0]  imem_data,   w_imem_data;
    logic [IW-1:0]  instruction, w_instruction;
    logic           ivalid,      w_ivalid;
    logic [PCW-1:0] pc,          w_pc;
    logic [PCW-1:0] prev,        w_prev;

    // Memory content: word at address a is a + 0x100.
    assign imem_data   = 32'(imem_addr) + 32'h100;
    assign w_imem_data = 32'(w_imem_addr) + 32'h100;

    always #5 clock = ~clock;

    fetch_unit u_dut (
        .clock(clock), .reset(reset), .pcchange(pcchange), .pcjumpenable(pcjumpenable),
        .pclocation(pclocation), .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .instruction(instruction),
        .instruction_valid(ivalid), .programcounter(pc), .previous_programcounter(prev)
    );

    fetch_unit #(.RESET_VECTOR(20'hFFFFF)) u_wrap (
        .clock(clock), .reset(reset), .pcchange(pcchange), .pcjumpenable(pcjumpenable),
        .pclocation(pclocation), .stall(stall), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ack(imem_ack), .imem_data(w_imem_data), .instruction(w_instruction),
        .instruction_valid(w_ivalid), .programcounter(w_pc), .previous_programcounter(w_prev)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model of the fetch stage, kept as a few flags and values.
    bit             m_started;   // first cycle after reset has passed
    bit             m_parked;    // holding a stalled instruction, no fetch
    bit             m_drain;     // waiting for an orphaned request's ack
    bit             m_valid;
    logic [PCW-1:0] m_pc, m_prev, m_drain_addr;
    logic [IW-1:0]  m_instr;

    // Values sampled before the edge of the most recent step.
    logic           s_req, s_wreq;
    logic [PCW-1:0] s_addr, s_waddr;

    task automatic model_reset();
        m_started = 0; m_parked = 0; m_drain = 0; m_valid = 0;
        m_pc = '0; m_prev = '0; m_drain_addr = '0; m_instr = '0;
    endtask

    task automatic step(input logic st, input logic [2:0] code, input logic [8:0] chg,
                        input logic [5:0] loc, input logic ak);
        logic           e_req;
        logic [PCW-1:0] e_addr, tgt;
        int             off;
        stall = st; pcjumpenable = code; pcchange = chg; pclocation = loc; imem_ack = ak;
        #1;
        if (!m_started)   e_req = 1'b0;
        else if (m_drain) e_req = 1'b1;
        else if (m_parked) e_req = 1'b0;
        else              e_req = !(m_valid && st);
        e_addr = m_drain ? m_drain_addr : m_pc;
        s_req = imem_req; s_addr = imem_addr; s_wreq = w_imem_req; s_waddr = w_imem_addr;
        chk("req", 32'(imem_req), 32'(e_req));
        if (e_req) chk("addr", 32'(imem_addr), 32'(e_addr));
        @(posedge clock);
        if (code >= 3'd1 && code <= 3'd4) begin
            if (code == 3'd1 || code == 3'd4) begin
                off = chg[8] ? int'(chg) - 512 : int'(chg);
                tgt = PCW'((int'(m_prev) + off + (1 << PCW)) % (1 << PCW));
            end else begin
                tgt = PCW'(loc);
            end
            m_drain = e_req && !ak;
            if (m_drain) m_drain_addr = e_addr;
            m_parked = 0; m_pc = tgt; m_valid = 0; m_started = 1;
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_drain) begin
            if (ak) m_drain = 0;
        end else if (m_parked) begin
            if (!st) begin m_parked = 0; m_valid = 0; end
        end else if (e_req && ak) begin
            m_instr = 32'(e_addr) + 32'h100;
            m_valid = 1; m_prev = m_pc; m_pc = m_pc + 1'b1; m_parked = st;
        end else if (!e_req) begin
            m_parked = 1;
        end else if (!st) begin
            m_valid = 0;
        end
        @(negedge clock);
        chk("valid", 32'(ivalid), 32'(m_valid));
        chk("instr", instruction, m_instr);
        chk("prev", 32'(prev), 32'(m_prev));
        chk("pc", 32'(pc), 32'(m_pc));
    endtask

    task automatic plain();
        step(1'b0, 3'd0, 9'd0, 6'd0, 1'b1);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clock);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_valid", 32'(ivalid), 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_wrap_addr", 32'(w_imem_addr), 32'hFFFFF);
        reset = 1'b1;

        // Sequential fetch from reset
        plain();
        chk("boot_idle_req", 32'(s_req), 32'd0);
        chk("wrap_idle_req", 32'(s_wreq), 32'd0);
        plain();
        chk("boot_req", 32'(s_req), 32'd1);
        chk("boot_addr", 32'(s_addr), 32'd0);
        chk("seq0_valid", 32'(ivalid), 32'd1);
        chk("seq0_instr", instruction, 32'h100);
        chk("seq0_prev", 32'(prev), 32'd0);
        chk("wrap_first_addr", 32'(s_waddr), 32'hFFFFF);
        chk("wrap_first_instr", w_instruction, 32'h1000FF);
        chk("wrap_first_prev", 32'(w_prev), 32'hFFFFF);
        chk("wrap_next_pc", 32'(w_pc), 32'd0);
        plain();
        chk("seq1_instr", instruction, 32'h101);
        chk("seq1_prev", 32'(prev), 32'd1);
        chk("wrap_next_addr", 32'(s_waddr), 32'd0);
        plain();
        chk("seq2_instr", instruction, 32'h102);
        chk("seq2_prev", 32'(prev), 32'd2);
        repeat (3) plain();
        chk("at5_prev", 32'(prev), 32'd5);

        // Relative branch back by 3 from pc 5
        step(1'b0, 3'd1, 9'h1FD, 6'd0, 1'b1);
        chk("br_bubble", 32'(ivalid), 32'd0);
        plain();
        chk("br_addr", 32'(s_addr), 32'd2);
        chk("br_instr", instruction, 32'h102);

        // Absolute jump, then ignored codes
        step(1'b0, 3'd2, 9'd0, 6'h2A, 1'b1);
        step(1'b0, 3'd5, 9'd0, 6'd0, 1'b1);
        chk("jmp_addr", 32'(s_addr), 32'h2A);
        chk("jmp_instr", instruction, 32'h12A);
        step(1'b0, 3'd7, 9'h0FF, 6'h3F, 1'b1);
        chk("code5_addr", 32'(s_addr), 32'h2B);
        plain();
        chk("code7_addr", 32'(s_addr), 32'h2C);
        chk("code7_instr", instruction, 32'h12C);

        // Redirect during a 3-cycle memory wait
        step(1'b0, 3'd3, 9'd0, 6'd8, 1'b0);
        chk("wait_addr0", 32'(s_addr), 32'h2D);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 3'd0, 9'd0, 6'd0, 1'b0);
            chk("drain_req", 32'(s_req), 32'd1);
            chk("drain_addr", 32'(s_addr), 32'h2D);
            chk("drain_valid", 32'(ivalid), 32'd0);
        end
        plain();
        chk("drain_ack_addr", 32'(s_addr), 32'h2D);
        chk("drain_discard", 32'(ivalid), 32'd0);
        plain();
        chk("post_drain_addr", 32'(s_addr), 32'd8);
        chk("post_drain_instr", instruction, 32'h108);
        chk("post_drain_valid", 32'(ivalid), 32'd1);

        // Stall for 4 cycles with a live instruction
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'd0, 9'd0, 6'd0, 1'b1);
            chk("stall_req", 32'(s_req), 32'd0);
            chk("stall_instr", instruction, 32'h108);
            chk("stall_prev", 32'(prev), 32'd8);
        end
        plain();
        chk("unstall_req", 32'(s_req), 32'd0);
        plain();
        chk("resume_addr", 32'(s_addr), 32'd9);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [2:0] code;
            r = int'($urandom_range(0, 15));
            code = (r < 8) ? 3'd0 : 3'(r - 8);
            step(($urandom_range(0, 3) == 0), code, 9'($urandom), 6'($urandom),
                 ($urandom_range(0, 2) != 0));
        end

        // Asynchronous reset in the middle of a memory wait
        repeat (3) plain();
        stall = 1'b0; pcjumpenable = 3'd0; imem_ack = 1'b0;
        #1;
        chk("pre_reset_req", 32'(imem_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_req", 32'(imem_req), 32'd0);
        chk("async_addr", 32'(imem_addr), 32'd0);
        chk("async_valid", 32'(ivalid), 32'd0);
        chk("async_instr", instruction, 32'd0);
        chk("async_prev", 32'(prev), 32'd0);
        chk("async_pc", 32'(pc), 32'd0);
        chk("async_wrap_pc", 32'(w_pc), 32'hFFFFF);
        chk("async_wrap_req", 32'(w_imem_req), 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;

        // Relative +1 from the wrap point targets address 0
        plain();
        plain();
        chk("wrap2_prev", 32'(w_prev), 32'hFFFFF);
        step(1'b0, 3'd1, 9'h001, 6'd0, 1'b1);
        chk("wrap_br_valid", 32'(w_ivalid), 32'd0);
        chk("wrap_br_pc", 32'(w_pc), 32'd0);
        plain();
        chk("wrap_br_req", 32'(s_wreq), 32'd1);
        chk("wrap_br_addr", 32'(s_waddr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
